// File: rtl/apb_master_if.sv
// Local command/response and APB bus signals of the single-slave APB requester.
// The master modport is the requester's view; the slave modport is the far side.
interface apb_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tmo;
  logic              psel0;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, pslverr, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
           psel0, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, pslverr, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
           psel0, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-slave APB requester: one command at a time, SETUP->ACCESS transfer,
// one-cycle response pulse, and a wait-state watchdog that aborts stuck transfers.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          preset,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t            r_state;
  logic [7:0]        r_wait_cnt;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_tmo;
  logic              r_psel0;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  logic w_accept;
  logic w_last_wait;

  assign w_accept    = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;
  assign w_last_wait = (r_wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_psel0     <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_pwrite    <= bus.cmd_write;
            r_paddr     <= bus.cmd_addr;
            // Reads leave pwdata at its last written value rather than picking up junk.
            if (bus.cmd_write) begin
              r_pwdata <= bus.cmd_wdata;
            end
            r_psel0 <= 1'b1;
            r_state <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (bus.pready) begin
            r_rsp_rdata <= (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
            r_rsp_err   <= bus.pslverr;
            r_rsp_tmo   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_psel0     <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_RESP;
          end else if (w_last_wait) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_tmo   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_psel0     <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          r_wait_cnt  <= '0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_tmo   = r_rsp_tmo;
  assign bus.psel0     = r_psel0;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, random transfers against a memory
// reference model, plus hand-written reset sequences.
module tb_apb_master;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic preset;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_W(8), .DATA_W(8)) bus();

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .preset (preset),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_xfer = 0;

  logic [7:0] ref_mem   [256];
  logic [7:0] slave_mem [256];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic       slverr;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_tmo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outcome of a command from the transfer rules alone.
  task automatic predict(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input int waits, input logic slverr,
                         output logic [7:0] rdata, output logic err, output logic tmo);
    tmo   = (waits >= TIMEOUT);
    err   = tmo || slverr;
    rdata = (!wr && !err) ? ref_mem[addr] : 8'h00;
    if (wr && !err) ref_mem[addr] = wdata;
  endtask

  // Issues one command and plays the slave, with pready after 'waits' ACCESS wait states.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input int waits, input logic slverr,
                      output logic [7:0] rdata, output logic err, output logic tmo);
    int t;
    int acc;
    int exp_acc;
    t = 0;
    while (!bus.cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(negedge clk);
    // Scramble the command inputs: the DUT must hold what it accepted.
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = 8'($urandom);
    chk("setup_ctl", 32'({bus.psel0, bus.penable, bus.cmd_ready, bus.rsp_valid}), 32'b1000);
    chk("setup_paddr", 32'(bus.paddr), 32'(addr));
    chk("setup_pwrite", 32'(bus.pwrite), 32'(wr));
    bus.pready  = 1'($urandom);
    bus.pslverr = 1'($urandom);
    bus.prdata  = 8'($urandom);
    acc = 0;
    forever begin
      @(negedge clk);
      if (!bus.penable || acc > TIMEOUT + 2) break;
      chk("access_ctl", 32'({bus.psel0, bus.cmd_ready, bus.rsp_valid}), 32'b100);
      chk("access_paddr", 32'(bus.paddr), 32'(addr));
      chk("access_pwrite", 32'(bus.pwrite), 32'(wr));
      if (wr) chk("access_pwdata", 32'(bus.pwdata), 32'(wdata));
      if (acc == waits) begin
        bus.pready  = 1'b1;
        bus.pslverr = slverr;
        bus.prdata  = wr ? 8'($urandom) : slave_mem[bus.paddr];
        if (wr && !slverr) slave_mem[bus.paddr] = bus.pwdata;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'($urandom);
        bus.prdata  = 8'($urandom);
      end
      acc++;
    end
    exp_acc = (waits >= TIMEOUT) ? TIMEOUT : waits + 1;
    chk("access_cycles", 32'(acc), 32'(exp_acc));
    chk("resp_ctl", 32'({bus.psel0, bus.penable, bus.rsp_valid, bus.cmd_ready}), 32'b0010);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    tmo   = bus.rsp_tmo;
    bus.pready  = 1'($urandom);
    bus.pslverr = 1'($urandom);
    @(negedge clk);
    chk("post_resp", 32'({bus.rsp_valid, bus.cmd_ready, bus.psel0}), 32'b010);
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    n_xfer++;
    $display("xfer %0d wr=%0d addr=%02h wdata=%02h waits=%0d slverr=%0d -> rdata=%02h err=%0d tmo=%0d",
             n_xfer, wr, addr, wdata, waits, slverr, rdata, err, tmo);
  endtask

  vec_t vecs[13];

  initial begin
    logic [7:0] rd;
    logic       er;
    logic       tm;
    logic [7:0] m_rd;
    logic       m_er;
    logic       m_tm;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic       slverr;
    int         t;

    vecs[0]  = '{1'b1, 8'd35,  8'd56,   0,   1'b0, 8'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd35,  8'd0,    0,   1'b0, 8'd56, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'd25,  8'd78,   0,   1'b0, 8'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd25,  8'd0,    0,   1'b0, 8'd78, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'd60,  8'h3C,   3,   1'b0, 8'd0,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'd60,  8'd0,    3,   1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'd200, 8'd0,    0,   1'b1, 8'd0,  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'd90,  8'h11,   300, 1'b0, 8'd0,  1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'd90,  8'd0,    0,   1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'd35,  8'd0,    15,  1'b0, 8'd56, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'd35,  8'h99,   15,  1'b1, 8'd0,  1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'd35,  8'd0,    16,  1'b0, 8'd0,  1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'd35,  8'd0,    0,   1'b0, 8'd56, 1'b0, 1'b0};

    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'(i) ^ 8'hA5;
      slave_mem[i] = 8'(i) ^ 8'hA5;
    end

    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_tmo,
                           bus.psel0, bus.penable, bus.pwrite}), 32'd0);
    chk("reset_data", 32'({bus.paddr, bus.pwdata, bus.rsp_rdata}), 32'd0);
    preset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      predict(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].slverr, m_rd, m_er, m_tm);
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].slverr, rd, er, tm);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_tmo", i), 32'(tm), 32'(vecs[i].exp_tmo));
    end

    for (int i = 0; i < 40; i++) begin
      wr     = 1'($urandom);
      addr   = 8'($urandom_range(0, 15));
      wdata  = 8'($urandom);
      case ($urandom_range(0, 4))
        0, 1:    waits = 0;
        2:       waits = $urandom_range(1, 3);
        default: waits = $urandom_range(0, 20);
      endcase
      slverr = ($urandom_range(0, 4) == 0);
      predict(wr, addr, wdata, waits, slverr, m_rd, m_er, m_tm);
      xfer(wr, addr, wdata, waits, slverr, rd, er, tm);
      chk("rand_rdata", 32'(rd), 32'(m_rd));
      chk("rand_err", 32'(er), 32'(m_er));
      chk("rand_tmo", 32'(tm), 32'(m_tm));
    end

    // Reset pulsed while the slave is stalling in ACCESS: transfer must vanish silently.
    t = 0;
    while (!bus.cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    @(negedge clk);
    chk("rst_pre_access", 32'({bus.psel0, bus.penable}), 32'b11);
    #2;
    preset = 1'b1;
    #1;
    chk("rst_async_drop", 32'({bus.psel0, bus.penable, bus.cmd_ready, bus.rsp_valid}), 32'd0);
    @(negedge clk);
    preset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'({bus.rsp_valid, bus.psel0}), 32'd0);
    end
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    predict(1'b1, 8'd5, 8'h77, 0, 1'b0, m_rd, m_er, m_tm);
    xfer(1'b1, 8'd5, 8'h77, 0, 1'b0, rd, er, tm);
    chk("rst_write_err", 32'(er), 32'd0);
    predict(1'b0, 8'd5, 8'h00, 1, 1'b0, m_rd, m_er, m_tm);
    xfer(1'b0, 8'd5, 8'h00, 1, 1'b0, rd, er, tm);
    chk("rst_read_rdata", 32'(rd), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end
endmodule
